// File: rtl/mem_arbiter_if.sv
// Client-side request/response bundle and system bus pins of mem_arbiter.
// The arbiter uses the slave modport; clients and the bus model use master.
interface mem_arbiter_if #(
    parameter int NPORTS         = 2,
    parameter int ADDRSZ         = 64,
    parameter int BLOCKSZ        = 512,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13
);
    logic [NPORTS-1:0]         req_valid;
    logic [NPORTS-1:0]         req_write;
    logic [NPORTS*ADDRSZ-1:0]  req_addr;
    logic [NPORTS*BLOCKSZ-1:0] req_wdata;
    logic [NPORTS-1:0]         req_ready;
    logic [NPORTS-1:0]         resp_valid;
    logic [BLOCKSZ-1:0]        resp_data;

    logic                      bus_reqcyc;
    logic [BUS_DATA_WIDTH-1:0] bus_req;
    logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
    logic                      bus_reqack;
    logic                      bus_respcyc;
    logic                      bus_respack;
    logic [BUS_DATA_WIDTH-1:0] bus_resp;
    logic [BUS_TAG_WIDTH-1:0]  bus_resptag;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        input  bus_reqack, bus_respcyc, bus_resp, bus_resptag,
        output req_ready, resp_valid, resp_data,
        output bus_reqcyc, bus_req, bus_reqtag, bus_respack
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        output bus_reqack, bus_respcyc, bus_resp, bus_resptag,
        input  req_ready, resp_valid, resp_data,
        input  bus_reqcyc, bus_req, bus_reqtag, bus_respack
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin block-memory arbiter: NPORTS clients share one system bus,
// one full-block read or write-back outstanding at a time.
module mem_arbiter #(
    parameter int NPORTS         = 2,
    parameter int ADDRSZ         = 64,
    parameter int BLOCKSZ        = 512,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter logic [BUS_TAG_WIDTH-1:0] TAG_READ  = 13'h1100,
    parameter logic [BUS_TAG_WIDTH-1:0] TAG_WRITE = 13'h0100
) (
    input logic         clk,
    input logic         reset,
    mem_arbiter_if.slave io
);
    localparam int BEATS = BLOCKSZ / BUS_DATA_WIDTH;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PW    = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int OFFB  = $clog2(BLOCKSZ / 8);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [PW-1:0] LAST_PORT = PW'(NPORTS - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WDATA,
        RDATA,
        DONE
    } state_t;

    state_t                    state;
    logic [PW-1:0]             ptr;
    logic [PW-1:0]             gnt;
    logic [BW-1:0]             beat;
    logic                      wr;
    logic [BLOCKSZ-1:0]        wdata;
    logic                      reqcyc;
    logic [BUS_DATA_WIDTH-1:0] req_q;
    logic [BUS_TAG_WIDTH-1:0]  reqtag;
    logic [NPORTS-1:0]         resp_valid_q;
    logic [BLOCKSZ-1:0]        resp_data_q;

    logic                      found;
    logic [PW-1:0]             gnt_idx;
    logic [ADDRSZ-1:0]         sel_addr;
    logic [ADDRSZ-1:0]         aligned;
    logic                      unused_ok;

    // Search from the pointer, wrapping, for the first pending port.
    always_comb begin
        int j;
        found   = 1'b0;
        gnt_idx = ptr;
        j       = 0;
        for (int i = 0; i < NPORTS; i++) begin
            j = (int'(ptr) + i) % NPORTS;
            if (!found && io.req_valid[j]) begin
                found   = 1'b1;
                gnt_idx = PW'(j);
            end
        end
    end

    assign sel_addr = io.req_addr[gnt_idx*ADDRSZ +: ADDRSZ];
    assign aligned  = {sel_addr[ADDRSZ-1:OFFB], {OFFB{1'b0}}};

    assign io.req_ready = (state == IDLE && found && !reset)
                        ? (NPORTS'(1) << gnt_idx) : '0;
    assign io.bus_respack = (state == RDATA) && io.bus_respcyc && !reset;

    assign io.bus_reqcyc = reqcyc;
    assign io.bus_req    = req_q;
    assign io.bus_reqtag = reqtag;
    assign io.resp_valid = resp_valid_q;
    assign io.resp_data  = resp_data_q;

    // Response tags are not needed with a single outstanding transaction.
    assign unused_ok = ^{io.bus_resptag, sel_addr[OFFB-1:0]};

    // Transaction FSM with registered bus and response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= '0;
            gnt          <= '0;
            beat         <= '0;
            wr           <= 1'b0;
            wdata        <= '0;
            reqcyc       <= 1'b0;
            req_q        <= '0;
            reqtag       <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    resp_valid_q <= '0;
                    if (found) begin
                        gnt    <= gnt_idx;
                        wr     <= io.req_write[gnt_idx];
                        wdata  <= io.req_wdata[gnt_idx*BLOCKSZ +: BLOCKSZ];
                        reqcyc <= 1'b1;
                        req_q  <= BUS_DATA_WIDTH'(aligned);
                        reqtag <= io.req_write[gnt_idx] ? TAG_WRITE : TAG_READ;
                        ptr    <= (gnt_idx == LAST_PORT) ? '0 : gnt_idx + 1'b1;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    if (io.bus_reqack) begin
                        beat <= '0;
                        if (wr) begin
                            req_q <= wdata[BUS_DATA_WIDTH-1:0];
                            wdata <= wdata >> BUS_DATA_WIDTH;
                            state <= WDATA;
                        end else begin
                            reqcyc <= 1'b0;
                            req_q  <= '0;
                            reqtag <= '0;
                            state  <= RDATA;
                        end
                    end
                end
                WDATA: begin
                    if (beat == LAST_BEAT) begin
                        reqcyc       <= 1'b0;
                        req_q        <= '0;
                        reqtag       <= '0;
                        resp_valid_q <= NPORTS'(1) << gnt;
                        state        <= DONE;
                    end else begin
                        beat  <= beat + 1'b1;
                        req_q <= wdata[BUS_DATA_WIDTH-1:0];
                        wdata <= wdata >> BUS_DATA_WIDTH;
                    end
                end
                RDATA: begin
                    if (io.bus_respcyc) begin
                        resp_data_q[beat*BUS_DATA_WIDTH +: BUS_DATA_WIDTH]
                            <= io.bus_resp;
                        if (beat == LAST_BEAT) begin
                            resp_valid_q <= NPORTS'(1) << gnt;
                            state        <= DONE;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                DONE: begin
                    resp_valid_q <= '0;
                    beat         <= '0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: reads, writes, arbitration order,
// response gaps, mid-burst reset and spurious bus responses.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mem_arbiter_if bus_if ();

    mem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus_if.slave)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Grants already issued: completes REQ with an ack and 8 back-to-back beats.
    task automatic run_read(input logic [63:0] base);
        bus_if.bus_reqack = 1'b1;
        tick();
        bus_if.bus_reqack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus_if.bus_respcyc = 1'b1;
            bus_if.bus_resp    = base + 64'(i);
            tick();
        end
        bus_if.bus_respcyc = 1'b0;
        bus_if.bus_resp    = '0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        n_cmp++;
        if (bus_if.req_ready !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_req_ready got %b want 00", bus_if.req_ready);
        end
        n_cmp++;
        if (bus_if.resp_valid !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_resp_valid got %b want 00", bus_if.resp_valid);
        end
        n_cmp++;
        if (bus_if.resp_data !== 512'd0) begin
            n_bad++;
            $display("FAIL reset_resp_data got %h want 0", bus_if.resp_data[63:0]);
        end
        n_cmp++;
        if (bus_if.bus_reqcyc !== 1'b0 || bus_if.bus_req !== 64'd0
            || bus_if.bus_reqtag !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_bus got cyc=%b req=%h tag=%h want 0/0/0",
                     bus_if.bus_reqcyc, bus_if.bus_req, bus_if.bus_reqtag);
        end
        n_cmp++;
        if (bus_if.bus_respack !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_respack got %b want 0", bus_if.bus_respack);
        end
    endtask

    task automatic test_single_read;
        bus_if.req_write      = 2'b00;
        bus_if.req_addr[63:0] = 64'h1234;
        bus_if.req_valid      = 2'b01;
        #1;
        n_cmp++;
        if (bus_if.req_ready !== 2'b01) begin
            n_bad++;
            $display("FAIL rd_grant got %b want 01", bus_if.req_ready);
        end
        tick();
        bus_if.req_valid      = 2'b00;
        bus_if.req_addr[63:0] = 64'h0;
        #1;
        n_cmp++;
        if (bus_if.bus_reqcyc !== 1'b1 || bus_if.bus_req !== 64'h1200
            || bus_if.bus_reqtag !== 13'h1100) begin
            n_bad++;
            $display("FAIL rd_req got cyc=%b req=%h tag=%h want 1/1200/1100",
                     bus_if.bus_reqcyc, bus_if.bus_req, bus_if.bus_reqtag);
        end
        tick();
        n_cmp++;
        if (bus_if.bus_reqcyc !== 1'b1 || bus_if.bus_req !== 64'h1200) begin
            n_bad++;
            $display("FAIL rd_req_hold got cyc=%b req=%h want 1/1200",
                     bus_if.bus_reqcyc, bus_if.bus_req);
        end
        run_read(64'h1000);
        n_cmp++;
        if (bus_if.resp_valid !== 2'b01) begin
            n_bad++;
            $display("FAIL rd_resp_valid got %b want 01", bus_if.resp_valid);
        end
        n_cmp++;
        if (bus_if.resp_data[63:0] !== 64'h1000
            || bus_if.resp_data[511:448] !== 64'h1007) begin
            n_bad++;
            $display("FAIL rd_resp_data got %h/%h want 1000/1007",
                     bus_if.resp_data[63:0], bus_if.resp_data[511:448]);
        end
        tick();
        n_cmp++;
        if (bus_if.resp_valid !== 2'b00) begin
            n_bad++;
            $display("FAIL rd_resp_pulse got %b want 00", bus_if.resp_valid);
        end
    endtask

    task automatic test_contention;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus_if.req_write        = 2'b00;
        bus_if.req_addr[63:0]   = 64'h40;
        bus_if.req_addr[127:64] = 64'h2000;
        bus_if.req_valid        = 2'b11;
        #1;
        n_cmp++;
        if (bus_if.req_ready !== 2'b01) begin
            n_bad++;
            $display("FAIL arb_first got %b want 01", bus_if.req_ready);
        end
        tick();
        bus_if.req_valid = 2'b10;
        #1;
        n_cmp++;
        if (bus_if.bus_req !== 64'h40 || bus_if.req_ready !== 2'b00) begin
            n_bad++;
            $display("FAIL arb_req0 got req=%h rdy=%b want 40/00",
                     bus_if.bus_req, bus_if.req_ready);
        end
        run_read(64'h2000);
        n_cmp++;
        if (bus_if.resp_valid !== 2'b01 || bus_if.req_ready !== 2'b00) begin
            n_bad++;
            $display("FAIL arb_done0 got vld=%b rdy=%b want 01/00",
                     bus_if.resp_valid, bus_if.req_ready);
        end
        tick();
        n_cmp++;
        if (bus_if.req_ready !== 2'b10) begin
            n_bad++;
            $display("FAIL arb_second got %b want 10", bus_if.req_ready);
        end
        tick();
        bus_if.req_valid = 2'b00;
        #1;
        n_cmp++;
        if (bus_if.bus_req !== 64'h2000) begin
            n_bad++;
            $display("FAIL arb_req1 got %h want 2000", bus_if.bus_req);
        end
        run_read(64'h3000);
        n_cmp++;
        if (bus_if.resp_valid !== 2'b10 || bus_if.resp_data[63:0] !== 64'h3000) begin
            n_bad++;
            $display("FAIL arb_done1 got vld=%b d0=%h want 10/3000",
                     bus_if.resp_valid, bus_if.resp_data[63:0]);
        end
        tick();
        bus_if.req_valid = 2'b11;
        #1;
        n_cmp++;
        if (bus_if.req_ready !== 2'b01) begin
            n_bad++;
            $display("FAIL arb_rotate got %b want 01", bus_if.req_ready);
        end
        tick();
        bus_if.req_valid = 2'b00;
        run_read(64'h3100);
        tick();
    endtask

    task automatic test_write;
        bus_if.req_write          = 2'b10;
        bus_if.req_addr[127:64]   = 64'h80;
        for (int i = 0; i < 8; i++)
            bus_if.req_wdata[512 + i*64 +: 64] = 64'hA0 + 64'(i);
        bus_if.req_valid = 2'b10;
        #1;
        n_cmp++;
        if (bus_if.req_ready !== 2'b10) begin
            n_bad++;
            $display("FAIL wr_grant got %b want 10", bus_if.req_ready);
        end
        tick();
        bus_if.req_valid = 2'b00;
        bus_if.req_write = 2'b00;
        bus_if.req_wdata = '0;
        #1;
        n_cmp++;
        if (bus_if.bus_reqcyc !== 1'b1 || bus_if.bus_req !== 64'h80
            || bus_if.bus_reqtag !== 13'h0100) begin
            n_bad++;
            $display("FAIL wr_req got cyc=%b req=%h tag=%h want 1/80/0100",
                     bus_if.bus_reqcyc, bus_if.bus_req, bus_if.bus_reqtag);
        end
        bus_if.bus_reqack = 1'b1;
        tick();
        bus_if.bus_reqack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (bus_if.bus_reqcyc !== 1'b1 || bus_if.bus_req !== 64'hA0 + 64'(i)) begin
                n_bad++;
                $display("FAIL wr_beat%0d got cyc=%b data=%h want 1/%h",
                         i, bus_if.bus_reqcyc, bus_if.bus_req, 64'hA0 + 64'(i));
            end
            tick();
        end
        n_cmp++;
        if (bus_if.resp_valid !== 2'b10 || bus_if.bus_reqcyc !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_done got vld=%b cyc=%b want 10/0",
                     bus_if.resp_valid, bus_if.bus_reqcyc);
        end
        n_cmp++;
        if (bus_if.resp_data[63:0] !== 64'h3100) begin
            n_bad++;
            $display("FAIL wr_resp_data got %h want 3100", bus_if.resp_data[63:0]);
        end
        tick();
    endtask

    task automatic test_beat_gaps;
        logic [511:0] exp_blk;
        logic         cyc;
        for (int i = 0; i < 8; i++)
            exp_blk[i*64 +: 64] = 64'h5000 + 64'(i);
        bus_if.req_write      = 2'b00;
        bus_if.req_addr[63:0] = 64'h1FC0;
        bus_if.req_valid      = 2'b01;
        #1;
        n_cmp++;
        if (bus_if.req_ready !== 2'b01) begin
            n_bad++;
            $display("FAIL gap_grant got %b want 01", bus_if.req_ready);
        end
        tick();
        bus_if.req_valid  = 2'b00;
        bus_if.bus_reqack = 1'b1;
        tick();
        bus_if.bus_reqack = 1'b0;
        for (int k = 0; k < 15; k++) begin
            cyc = (k % 2 == 0);
            bus_if.bus_respcyc = cyc;
            bus_if.bus_resp    = cyc ? 64'h5000 + 64'(k / 2) : 64'hDEAD;
            #1;
            n_cmp++;
            if (bus_if.bus_respack !== cyc || bus_if.resp_valid !== 2'b00) begin
                n_bad++;
                $display("FAIL gap_cycle%0d got ack=%b vld=%b want %b/00",
                         k, bus_if.bus_respack, bus_if.resp_valid, cyc);
            end
            tick();
        end
        bus_if.bus_respcyc = 1'b0;
        bus_if.bus_resp    = '0;
        n_cmp++;
        if (bus_if.resp_valid !== 2'b01 || bus_if.resp_data !== exp_blk) begin
            n_bad++;
            $display("FAIL gap_done got vld=%b d0=%h d7=%h want 01/5000/5007",
                     bus_if.resp_valid, bus_if.resp_data[63:0],
                     bus_if.resp_data[511:448]);
        end
        tick();
    endtask

    task automatic test_reset_midburst;
        bus_if.req_write        = 2'b00;
        bus_if.req_addr[127:64] = 64'h4000;
        bus_if.req_valid        = 2'b10;
        #1;
        n_cmp++;
        if (bus_if.req_ready !== 2'b10) begin
            n_bad++;
            $display("FAIL mid_grant got %b want 10", bus_if.req_ready);
        end
        tick();
        bus_if.req_valid  = 2'b00;
        bus_if.bus_reqack = 1'b1;
        tick();
        bus_if.bus_reqack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_if.bus_respcyc = 1'b1;
            bus_if.bus_resp    = 64'h6000 + 64'(i);
            tick();
        end
        bus_if.bus_respcyc = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_cmp++;
        if (bus_if.resp_valid !== 2'b00 || bus_if.bus_reqcyc !== 1'b0
            || bus_if.bus_req !== 64'd0 || bus_if.bus_reqtag !== 13'd0
            || bus_if.bus_respack !== 1'b0 || bus_if.req_ready !== 2'b00) begin
            n_bad++;
            $display("FAIL mid_outputs got vld=%b cyc=%b req=%h tag=%h ack=%b want all 0",
                     bus_if.resp_valid, bus_if.bus_reqcyc, bus_if.bus_req,
                     bus_if.bus_reqtag, bus_if.bus_respack);
        end
        n_cmp++;
        if (bus_if.resp_data !== 512'd0) begin
            n_bad++;
            $display("FAIL mid_resp_data got %h want 0", bus_if.resp_data[63:0]);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (bus_if.resp_valid !== 2'b00) begin
                n_bad++;
                $display("FAIL mid_stale%0d got %b want 00", i, bus_if.resp_valid);
            end
        end
        bus_if.req_addr[63:0] = 64'h100;
        bus_if.req_valid      = 2'b01;
        #1;
        n_cmp++;
        if (bus_if.req_ready !== 2'b01) begin
            n_bad++;
            $display("FAIL mid_regrant got %b want 01", bus_if.req_ready);
        end
        tick();
        bus_if.req_valid = 2'b00;
        run_read(64'h7000);
        n_cmp++;
        if (bus_if.resp_valid !== 2'b01 || bus_if.resp_data[63:0] !== 64'h7000
            || bus_if.resp_data[511:448] !== 64'h7007) begin
            n_bad++;
            $display("FAIL mid_after got vld=%b d0=%h d7=%h want 01/7000/7007",
                     bus_if.resp_valid, bus_if.resp_data[63:0],
                     bus_if.resp_data[511:448]);
        end
        tick();
    endtask

    task automatic test_spurious;
        bus_if.bus_respcyc = 1'b1;
        bus_if.bus_resp    = 64'hBAD;
        #1;
        n_cmp++;
        if (bus_if.bus_respack !== 1'b0) begin
            n_bad++;
            $display("FAIL spur_ack got %b want 0", bus_if.bus_respack);
        end
        tick();
        tick();
        n_cmp++;
        if (bus_if.resp_data[63:0] !== 64'h7000 || bus_if.resp_valid !== 2'b00) begin
            n_bad++;
            $display("FAIL spur_data got d0=%h vld=%b want 7000/00",
                     bus_if.resp_data[63:0], bus_if.resp_valid);
        end
        bus_if.bus_respcyc = 1'b0;
        bus_if.bus_resp    = '0;
    endtask

    initial begin
        bus_if.req_valid   = '0;
        bus_if.req_write   = '0;
        bus_if.req_addr    = '0;
        bus_if.req_wdata   = '0;
        bus_if.bus_reqack  = 1'b0;
        bus_if.bus_respcyc = 1'b0;
        bus_if.bus_resp    = '0;
        bus_if.bus_resptag = '0;
        test_reset();
        test_single_read();
        test_contention();
        test_write();
        test_beat_gaps();
        test_reset_midburst();
        test_spurious();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Multi-client block-memory interface that generalises the single-requester memory fetch unit. It serves NPORTS clients, for example an instruction cache and a data cache, through one system bus, using round-robin arbitration. It supports full-block reads and full-block write-backs. It sits between the caches and the top-level bus pins, and one transaction is outstanding at a time.

Parameters:
NPORTS, 2, number of client ports; port 0 has the highest priority after reset
ADDRSZ, 64, client address width
BLOCKSZ, 512, cache block size in bits, transferred per transaction
BUS_DATA_WIDTH, 64, bus beat width; BEATS = BLOCKSZ/BUS_DATA_WIDTH (8)
BUS_TAG_WIDTH, 13, bus tag width
TAG_READ, 13'h1100, tag driven for read requests
TAG_WRITE, 13'h0100, tag driven for write requests

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  NPORTS  per-port request pending; held high until that port's req_ready
req_write  in  NPORTS  per-port request type: 1 = write block, 0 = read block
req_addr  in  NPORTS*ADDRSZ  per-port byte address; slice p is [p*ADDRSZ +: ADDRSZ]
req_wdata  in  NPORTS*BLOCKSZ  per-port write block; slice p is [p*BLOCKSZ +: BLOCKSZ]
req_ready  out  NPORTS  one-cycle grant pulse; request has been captured
resp_valid  out  NPORTS  one-cycle completion pulse to the granted port
resp_data  out  BLOCKSZ  read block; valid while resp_valid is high, shared by all ports
bus_reqcyc  out  1  bus request cycle
bus_req  out  BUS_DATA_WIDTH  request address or write beat
bus_reqtag  out  BUS_TAG_WIDTH  request tag
bus_reqack  in  1  bus accepted request
bus_respcyc  in  1  response beat valid
bus_respack  out  1  response beat accepted
bus_resp  in  BUS_DATA_WIDTH  response beat data
bus_resptag  in  BUS_TAG_WIDTH  response tag; ignored

Behaviour:
- Reset: state IDLE; all outputs 0; resp_data 0; round-robin pointer 0; beat counter 0. Reset in any state, including mid-burst, abandons the transaction. No resp_valid pulse is issued for an abandoned transaction.
- IDLE, arbitration:
  - The search starts at the pointer and wraps modulo NPORTS; the first port with req_valid high is granted.
  - req_ready[g] is driven combinationally high in the same cycle.
  - On the clock edge the block latches g, req_write[g], the address with its low log2(BLOCKSZ/8) bits zeroed, and req_wdata[g]. State becomes REQ and the pointer becomes (g+1) mod NPORTS.
  - With no req_valid high, the block stays in IDLE.
- REQ:
  - Drives bus_reqcyc=1, bus_req=aligned address, and bus_reqtag=TAG_WRITE or TAG_READ.
  - Holds these values until a cycle in which bus_reqack=1.
  - On that edge, state becomes WDATA for a write or RDATA for a read, and the beat counter is cleared.
- WDATA:
  - bus_reqcyc stays high and bus_req = wdata[beat*BUS_DATA_WIDTH +: BUS_DATA_WIDTH]; one beat per cycle, with beat 0 in the first WDATA cycle.
  - After beat BEATS-1, state becomes DONE.
- RDATA:
  - bus_reqcyc=0 and bus_respack = bus_respcyc (combinational).
  - Each cycle with bus_respcyc=1 stores bus_resp into resp_data[beat*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] and increments the beat counter. Gap cycles with bus_respcyc=0 are tolerated with no state change.
  - After beat BEATS-1 is stored, state becomes DONE.
- DONE: resp_valid[g]=1 for exactly one cycle, then state returns to IDLE.
  - resp_data holds its value until the next read overwrites it.
  - For writes, resp_data is unchanged.
- bus_respcyc outside RDATA is ignored and bus_respack stays 0 there.
- Latency: grant cycle + REQ cycles (at least 1) + BEATS beat cycles (minimum) + DONE cycle. Zero-wait minimum is BEATS+3 cycles from the grant to the resp_valid pulse.
- Fairness:
  - A port just served has the lowest priority at the next arbitration.
  - With all ports continuously requesting, grants rotate 0,1,...,NPORTS-1,0.
  - A single requesting port is granted on every IDLE visit.
- Clients may change req_* after req_ready; the captured copy is used.
- At most one req_ready bit and one resp_valid bit is high in any cycle.

Test Plan:
- Single read: port0 read at addr 0x1234; reqack after 2 cycles; beats 0x1000..0x1007 -> bus_req=0x1200 with tag 13'h1100. Then resp_valid=2'b01 and resp_data[63:0]=0x1000, [511:448]=0x1007.
- Contention: immediately after reset, port0 and port1 both request reads -> port0 granted first and served, then port1. A further request from both ports is granted port0 before port1 next, confirming round-robin order.
- Write: port1 write of wdata beats 0xA0..0xA7 to addr 0x80 -> bus_req=0x80 with tag 13'h0100. After reqack, 8 consecutive cycles carry 0xA0..0xA7 with reqcyc high. Then resp_valid=2'b10.
- Beat gaps: read with bus_respcyc toggling 1,0,1,... -> exactly 8 beats captured in order; respack mirrors respcyc; no early resp_valid.
- Reset mid-burst: reset asserted after beat 3 of a read -> next cycle all outputs are 0 and state is IDLE. A later request completes normally with no stale resp_valid.
- Spurious response: bus_respcyc=1 while in IDLE -> respack stays 0 and resp_data is unchanged.
